// File: rtl/ps2_cmd_ctl.sv
// PS/2 keyboard command controller: sends host command bytes and LED updates, then awaits ACK (0xFA).
// Optional macro PS2_RESEND_EN: on 0xFE the current byte is re-sent up to MAX_RETRY times.
module ps2_cmd_ctl #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic       led_req,
  input  logic [2:0] leds,
  output logic       tx_wren,
  output logic [7:0] tx_d,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       cmd_done,
  output logic       err,
  output logic       busy
);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_SETLED = 8'hED;

  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, TX_START, TX_DONE, WAIT_RSP, NEXT, FINISH
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_led_pend, w_led_pend_nxt;
  logic        r_job_led, w_job_led_nxt;
  logic        r_second, w_second_nxt;
  logic [2:0]  r_leds, w_leds_nxt;
  logic [7:0]  r_tx_d, w_tx_d_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        w_retry_ok;

`ifdef PS2_RESEND_EN
  logic [1:0]  r_retry, w_retry_nxt;
  assign w_retry_ok = (r_retry < MAX_RETRY);
`else
  assign w_retry_ok = 1'b0 && (MAX_RETRY != 2'd0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_led_pend <= 1'b0;
      r_job_led  <= 1'b0;
      r_second   <= 1'b0;
      r_leds     <= 3'b000;
      r_tx_d     <= 8'h00;
      r_err      <= 1'b0;
      r_cnt      <= 16'd0;
`ifdef PS2_RESEND_EN
      r_retry    <= 2'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_led_pend <= w_led_pend_nxt;
      r_job_led  <= w_job_led_nxt;
      r_second   <= w_second_nxt;
      r_leds     <= w_leds_nxt;
      r_tx_d     <= w_tx_d_nxt;
      r_err      <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
`ifdef PS2_RESEND_EN
      r_retry    <= w_retry_nxt;
`endif
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_led_pend_nxt = r_led_pend | led_req;
    w_job_led_nxt  = r_job_led;
    w_second_nxt   = r_second;
    w_leds_nxt     = r_leds;
    w_tx_d_nxt     = r_tx_d;
    w_err_nxt      = r_err;
    w_cnt_nxt      = r_cnt;
`ifdef PS2_RESEND_EN
    w_retry_nxt    = r_retry;
`endif
    unique case (r_state)
      IDLE: begin
        if (cmd_req) begin
          w_job_led_nxt = 1'b0;
          w_tx_d_nxt    = cmd_byte;
          w_err_nxt     = 1'b0;
          w_state_nxt   = LOAD;
        end else if (r_led_pend) begin
          // A pulse arriving in this very cycle stays pending rather than being dropped.
          w_led_pend_nxt = led_req;
          w_job_led_nxt  = 1'b1;
          w_leds_nxt     = leds;
          w_tx_d_nxt     = BYTE_SETLED;
          w_err_nxt      = 1'b0;
          w_state_nxt    = LOAD;
        end
      end
      LOAD: begin
        w_second_nxt = 1'b0;
`ifdef PS2_RESEND_EN
        w_retry_nxt  = 2'd0;
`endif
        w_state_nxt  = STROBE;
      end
      STROBE:   if (!tx_busy) w_state_nxt = TX_START;
      TX_START: if (tx_busy)  w_state_nxt = TX_DONE;
      TX_DONE: begin
        if (!tx_busy) begin
          w_cnt_nxt   = ACK_TIMEOUT;
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (r_cnt != 16'd0) w_cnt_nxt = r_cnt - 16'd1;
        if (rx_valid) begin
          if (rx_data == BYTE_ACK) begin
            w_state_nxt = NEXT;
          end else if ((rx_data == BYTE_RESEND) && w_retry_ok) begin
`ifdef PS2_RESEND_EN
            w_retry_nxt = r_retry + 2'd1;
`endif
            w_state_nxt = STROBE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = FINISH;
          end
        end else if (r_cnt <= 16'd1) begin
          // Timeout fires on the cycle the counter would reach zero.
          w_err_nxt   = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      NEXT: begin
        if (r_job_led && !r_second) begin
          w_tx_d_nxt   = {5'b00000, r_leds};
          w_second_nxt = 1'b1;
`ifdef PS2_RESEND_EN
          w_retry_nxt  = 2'd0;
`endif
          w_state_nxt  = STROBE;
        end else begin
          w_state_nxt  = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign tx_wren  = (r_state == STROBE) && !tx_busy;
  assign tx_d     = r_tx_d;
  assign cmd_done = (r_state == FINISH) && !r_job_led;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule
